bp_update_sequencer: RTL

BP_UPDATE_SEQUENCER -- requirements
Module: bp_update_sequencer

---
 rtl/bp_pkg.sv | 17 +
 rtl/bp_update_sequencer_if.sv | 22 ++
 rtl/bp_inflight_fifo.sv | 53 +++++
 rtl/bp_update_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update sequencer.
package bp_pkg;
    localparam int CNT_W = 16;
    localparam int PC_W  = 32;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            local_bit;
        logic            global_bit;
        logic            choice;
    } bp_entry_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;
endpackage

// File: rtl/bp_update_sequencer_if.sv
// Push/pop/flush handshake between the sequencer and its in-flight queue.
interface bp_update_sequencer_if;
    import bp_pkg::*;

    logic      push;
    logic      pop;
    logic      flush;
    bp_entry_t wdata;
    bp_entry_t rdata;
    logic      full;
    logic      empty;

    modport master (
        output push, pop, flush, wdata,
        input  rdata, full, empty
    );

    modport slave (
        input  push, pop, flush, wdata,
        output rdata, full, empty
    );
endinterface

// File: rtl/bp_inflight_fifo.sv
// In-order queue of issued branches awaiting resolution.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic             clock,
    input logic             reset,
    bp_update_sequencer_if.slave f
);
    localparam int AW = $clog2(DEPTH);

    bp_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign f.full  = (count == (AW+1)'(DEPTH));
    assign f.empty = (count == '0);
    assign f.rdata = mem[rd_ptr];

    assign do_push = f.push && !f.full;
    assign do_pop  = f.pop && !f.empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= f.wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (f.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/bp_update_sequencer.sv
// Predictor update sequencer: INIT table sweep, then in-order training.
// Optional BP_STATS_EN adds saturating branch/mispredict counters.
module bp_update_sequencer
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic [IDX_W-1:0] pred_pc,
    input  logic             pred_local,
    input  logic             pred_global,
    input  logic             pred_choice,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             res_ready,
    input  logic             flush,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_pc,
    output logic             upd_taken,
    output logic             upd_init,
    output logic             upd_choice_en,
    output logic             upd_choice_dir,
    input  logic             upd_ready,
    output logic             mispredict,
    output logic             init_busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    bp_state_e        state;
    bp_state_e        state_nx;
    bp_entry_t        head;
    logic             run;
    logic             push;
    logic             pop;
    logic             final_pred;
    logic             valid_nx;
    logic [IDX_W-1:0] pc_nx;
    logic             taken_nx;
    logic             init_nx;
    logic             cen_nx;
    logic             cdir_nx;
    logic             misp_nx;

    bp_update_sequencer_if fq ();

    bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .f     (fq.slave)
    );

    assign run        = (state == RUN);
    assign init_busy  = (state == INIT);
    assign head       = fq.rdata;
    // Flush blocks both sides of the queue for its cycle.
    assign pred_ready = run && !fq.full && !flush;
    assign res_ready  = run && !fq.empty && !flush
                        && (!upd_valid || upd_ready);
    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && res_ready;
    assign final_pred = head.choice ? head.global_bit : head.local_bit;

    assign fq.push  = push;
    assign fq.pop   = pop;
    assign fq.flush = run && flush;
    assign fq.wdata = '{pc:         PC_W'(pred_pc),
                        local_bit:  pred_local,
                        global_bit: pred_global,
                        choice:     pred_choice};

    always_comb begin
        state_nx = state;
        valid_nx = upd_valid;
        pc_nx    = upd_pc;
        taken_nx = upd_taken;
        init_nx  = upd_init;
        cen_nx   = upd_choice_en;
        cdir_nx  = upd_choice_dir;
        misp_nx  = 1'b0;
        unique case (state)
            INIT: begin
                if (upd_ready) begin
                    if (&upd_pc) begin
                        state_nx = RUN;
                        valid_nx = 1'b0;
                        init_nx  = 1'b0;
                    end else begin
                        pc_nx = upd_pc + 1'b1;
                    end
                end
            end
            RUN: begin
                if (pop) begin
                    valid_nx = 1'b1;
                    pc_nx    = IDX_W'(head.pc);
                    taken_nx = res_taken;
                    init_nx  = 1'b0;
                    cen_nx   = head.local_bit != head.global_bit;
                    cdir_nx  = head.global_bit == res_taken;
                    misp_nx  = final_pred != res_taken;
                end else if (upd_ready) begin
                    valid_nx = 1'b0;
                end
            end
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= INIT;
            upd_valid      <= 1'b1;
            upd_pc         <= '0;
            upd_taken      <= 1'b0;
            upd_init       <= 1'b1;
            upd_choice_en  <= 1'b0;
            upd_choice_dir <= 1'b0;
            mispredict     <= 1'b0;
        end else begin
            state          <= state_nx;
            upd_valid      <= valid_nx;
            upd_pc         <= pc_nx;
            upd_taken      <= taken_nx;
            upd_init       <= init_nx;
            upd_choice_en  <= cen_nx;
            upd_choice_dir <= cdir_nx;
            mispredict     <= misp_nx;
        end
    end

`ifdef BP_STATS_EN
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] mcnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bcnt <= '0;
            mcnt <= '0;
        end else begin
            if (pop && !(&bcnt))        bcnt <= bcnt + 1'b1;
            if (mispredict && !(&mcnt)) mcnt <= mcnt + 1'b1;
        end
    end

    assign branch_cnt  = bcnt;
    assign mispred_cnt = mcnt;
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif
endmodule
